// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared widths and constants for the 4x4 Vedic multiplier tile
//
// Purpose : common operand/product widths and the bidirectional-pin default.
// Contents: OPW            operand width (4)
//           PW             product width (8)
//           UIO_OE_DEFAULT output-enable value for the bidirectional bus
package vedic_pkg;

    localparam int OPW = 4;
    localparam int PW  = 8;

    localparam logic [7:0] UIO_OE_DEFAULT = 8'h00;

endpackage : vedic_pkg

// File: rtl/vedic_2x2.sv
// rtl/vedic_2x2.sv - combinational 2x2 Vedic multiplier cell
//
// Purpose : gate-level Urdhva-Tiryagbhyam 2-bit by 2-bit unsigned multiply.
// Ports   : a[1:0] multiplicand
//           b[1:0] multiplier
//           p[3:0] product a*b
module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);

    logic cross_hi;
    logic cross_lo;
    logic carry;
    logic top;

    // The two cross terms form the middle column; their AND is the carry
    // into the upper column. Kept as gates so the Vedic structure survives
    // synthesis instead of collapsing into a generic multiplier.
    assign cross_hi = a[1] & b[0];
    assign cross_lo = a[0] & b[1];
    assign carry    = cross_hi & cross_lo;
    assign top      = a[1] & b[1];

    assign p[0] = a[0] & b[0];
    assign p[1] = cross_hi ^ cross_lo;
    assign p[2] = top ^ carry;
    assign p[3] = top & carry;

endmodule : vedic_2x2

// File: rtl/tt_um_vedic_4x4.sv
// rtl/tt_um_vedic_4x4.sv - Tiny-Tapeout tile: registered 4x4 unsigned Vedic multiplier
//
// Purpose : multiplies ui_in[7:4] by ui_in[3:0] with four 2x2 Vedic cells and
//           a small adder tree, registering the 8-bit product on uo_out.
// Ports   : clk      rising-edge clock
//           rst_n    asynchronous reset, active-HIGH despite its name
//           ena      product register load enable
//           ui_in    [7:4] operand A, [3:0] operand B (unsigned)
//           uo_out   registered product A*B
//           uio_in   unused, never sampled
//           uio_out  constant 0
//           uio_oe   constant 0 (all bidirectional pins are inputs)
module tt_um_vedic_4x4
    import vedic_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [7:0]    ui_in,
    output logic [PW-1:0] uo_out,
    input  logic [7:0]    uio_in,
    output logic [7:0]    uio_out,
    output logic [7:0]    uio_oe
);

    logic [OPW-1:0] op_a;
    logic [OPW-1:0] op_b;
    logic [3:0]     q0;
    logic [3:0]     q1;
    logic [3:0]     q2;
    logic [3:0]     q3;
    logic [5:0]     s1;
    logic [3:0]     p_hi;
    logic [PW-1:0]  product;

    assign op_a = ui_in[7:4];
    assign op_b = ui_in[3:0];

    vedic_2x2 u_q0 (.a(op_a[1:0]), .b(op_b[1:0]), .p(q0));
    vedic_2x2 u_q1 (.a(op_a[3:2]), .b(op_b[1:0]), .p(q1));
    vedic_2x2 u_q2 (.a(op_a[1:0]), .b(op_b[3:2]), .p(q2));
    vedic_2x2 u_q3 (.a(op_a[3:2]), .b(op_b[3:2]), .p(q3));

    // Middle column: both cross products plus the upper half of q0.
    // Peaks at 9+9+2=20, so six bits are plenty.
    assign s1 = {2'b00, q1} + {2'b00, q2} + {4'b0000, q0[3:2]};

    // Upper nibble: q3 (max 9) plus s1[5:2] (max 5) never exceeds 15.
    assign p_hi = q3 + s1[5:2];

    assign product = {p_hi, s1[1:0], q0[1:0]};

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            uo_out <= '0;
        end else if (ena) begin
            uo_out <= product;
        end
    end

    assign uio_out = 8'h00;
    assign uio_oe  = UIO_OE_DEFAULT;

    // Reduced into a deliberately dead net so the unused bus is visibly
    // accounted for; nothing downstream reads it.
    logic unused_uio;
    assign unused_uio = &{1'b0, uio_in};

endmodule : tt_um_vedic_4x4

// File: tb/tb_tt_um_vedic_4x4.sv
// tb/tb_tt_um_vedic_4x4.sv - self-checking bench for tt_um_vedic_4x4
module tb_tt_um_vedic_4x4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int errors;

    tt_um_vedic_4x4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_product(input logic [7:0] v);
        int a;
        int b;
        a = int'(v) / 16;
        b = int'(v) % 16;
        return 8'(a * b);
    endfunction

    task automatic tick_and_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'hFF;
        uio_in = 8'h00;
        for (int i = 0; i < 2; i++) begin
            tick_and_sample();
            checks++;
            if (uo_out !== 8'h00) begin
                errors++;
                $display("FAIL reset_uo_out cycle %0d got %h want 00", i, uo_out);
            end
            checks++;
            if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
                errors++;
                $display("FAIL reset_uio got out=%h oe=%h want 00/00", uio_out, uio_oe);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_release_before_edge got %h want 00", uo_out);
        end
    endtask

    task automatic apply_and_check(input logic [7:0] v, input logic [7:0] want, input string name);
        @(negedge clk);
        ui_in = v;
        tick_and_sample();
        checks++;
        if (uo_out !== want) begin
            errors++;
            $display("FAIL %s ui_in=%h got %h want %h", name, v, uo_out, want);
        end
    endtask

    task automatic test_basic();
        ena = 1'b1;
        apply_and_check({4'd3, 4'd2}, 8'd6,  "basic_3x2");
        apply_and_check({4'd5, 4'd4}, 8'd20, "basic_5x4");
    endtask

    task automatic test_corners();
        apply_and_check({4'd15, 4'd15}, 8'hE1, "corner_15x15");
        apply_and_check({4'd9, 4'd0},   8'h00, "corner_9x0");
        apply_and_check({4'd0, 4'd9},   8'h00, "corner_0x9");
    endtask

    task automatic test_enable_latency();
        ena = 1'b1;
        apply_and_check({4'd5, 4'd4}, 8'd20, "latency_setup");
        @(negedge clk);
        ui_in = {4'd15, 4'd15};
        #2;
        checks++;
        if (uo_out !== 8'd20) begin
            errors++;
            $display("FAIL latency_before_edge got %h want %h", uo_out, 8'd20);
        end
        tick_and_sample();
        checks++;
        if (uo_out !== 8'hE1) begin
            errors++;
            $display("FAIL latency_after_edge got %h want E1", uo_out);
        end
        @(negedge clk);
        ena   = 1'b0;
        ui_in = {4'd7, 4'd6};
        for (int i = 0; i < 3; i++) begin
            tick_and_sample();
            checks++;
            if (uo_out !== 8'hE1) begin
                errors++;
                $display("FAIL enable_hold cycle %0d got %h want E1", i, uo_out);
            end
        end
        @(negedge clk);
        ena = 1'b1;
        tick_and_sample();
        checks++;
        if (uo_out !== 8'd42) begin
            errors++;
            $display("FAIL enable_resume got %h want %h", uo_out, 8'd42);
        end
    endtask

    task automatic test_async_reset();
        ena = 1'b1;
        apply_and_check(8'hFF, 8'hE1, "async_setup");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_immediate got %h want 00", uo_out);
        end
        checks++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_uio got out=%h oe=%h want 00/00", uio_out, uio_oe);
        end
        @(negedge clk);
        rst_n = 1'b0;
        ui_in = {4'd13, 4'd11};
        #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL async_release_hold got %h want 00", uo_out);
        end
        tick_and_sample();
        checks++;
        if (uo_out !== 8'd143) begin
            errors++;
            $display("FAIL async_release_load got %h want %h", uo_out, 8'd143);
        end
    endtask

    task automatic test_sweep();
        int bad;
        bad = 0;
        ena = 1'b1;
        for (int v = 0; v < 256; v++) begin
            @(negedge clk);
            ui_in  = 8'(v);
            uio_in = 8'($urandom);
            tick_and_sample();
            checks++;
            if (uo_out !== ref_product(8'(v))) begin
                errors++;
                bad++;
                if (bad <= 8)
                    $display("FAIL sweep ui_in=%h got %h want %h", v[7:0], uo_out, ref_product(8'(v)));
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] expected;
        logic [7:0] v;
        int bad;
        bad = 0;
        expected = uo_out === ref_product(ui_in) ? ref_product(ui_in) : 8'h00;
        // Start from a known state: load the current operands once.
        @(negedge clk);
        ena = 1'b1;
        ui_in = 8'h00;
        tick_and_sample();
        expected = 8'h00;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            v      = 8'($urandom);
            ui_in  = v;
            ena    = 1'($urandom_range(0, 3) != 0);
            uio_in = 8'($urandom);
            if (ena)
                expected = ref_product(v);
            tick_and_sample();
            checks++;
            if (uo_out !== expected || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
                errors++;
                bad++;
                if (bad <= 8)
                    $display("FAIL random i=%0d ui_in=%h ena=%b got %h want %h uio_out=%h uio_oe=%h",
                             i, v, ena, uo_out, expected, uio_out, uio_oe);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #1;
        test_reset();
        test_basic();
        test_corners();
        test_enable_latency();
        test_async_reset();
        test_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tt_um_vedic_4x4

// File: doc/tt_um_vedic_4x4.md
Name: tt_um_vedic_4x4

Overview:
- Tiny-Tapeout-style user tile implementing a 4x4 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier.
- The two 4-bit operands are packed on the dedicated input bus ui_in.
- The 8-bit product is registered and driven on uo_out.
- The bidirectional bus is unused and held as inputs.

Parameters:
- None. Widths are fixed: 4-bit operands, 8-bit product.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  reset, asynchronous, active-high (rst_n=1 resets); port name kept per codebase convention
- ena  input  1  tile enable; product register loads only when ena=1
- ui_in  input  8  [7:4]=operand A, [3:0]=operand B, unsigned
- uo_out  output  8  registered product A*B
- uio_in  input  8  unused, ignored
- uio_out  output  8  constant 8'h00
- uio_oe  output  8  constant 8'h00 (all bidirectional pins are inputs)

Behaviour:
- Reset (rst_n=1, asynchronous assert) forces uo_out=8'h00 immediately, independent of clk.
- Reset release takes effect on the next rising clk edge.
- uio_out=8'h00 and uio_oe=8'h00 at all times, including during reset.
- Combinational datapath: A=ui_in[7:4], B=ui_in[3:0]; P=A*B (8 bits, unsigned).
- The product cannot overflow; the maximum is 15*15=225=8'hE1.
- Vedic structure:
  - Split A=(Ah,Al) and B=(Bh,Bl) into 2-bit halves.
  - Form four 2x2 partial products: q0=Al*Bl, q1=Ah*Bl, q2=Al*Bh, q3=Ah*Bh (each 4 bits).
  - P[1:0]=q0[1:0].
  - s1 = q1 + q2 + {2'b00,q0[3:2]} (6-bit sum).
  - P[3:2]=s1[1:0].
  - P[7:4] = q3 + s1[5:2] (mod 16; no carry out is possible).
- 2x2 block: inputs a[1:0], b[1:0].
  - p0=a0&b0.
  - p1=(a1&b0)^(a0&b1), with carry c=(a1&b0)&(a0&b1).
  - p2=(a1&b1)^c.
  - p3=(a1&b1)&c.
- Register: on rising clk with rst_n=0 and ena=1, uo_out<=P. With ena=0, uo_out holds its value.
- Latency: one clock edge.
  - An operand change is visible on uo_out after the first rising edge at which it is sampled.
  - Operand changes between edges never glitch uo_out.
- Reset asserted mid-operation discards the in-flight product; uo_out=0 until the first loading edge after release.
- uio_in is never sampled. No X must propagate from it.

Decomposition:
- Shared package vedic_pkg:
  - OPW=4 (operand width)
  - PW=8 (product width)
  - UIO_OE_DEFAULT=8'h00
- One sub-module, vedic_2x2: purely combinational 2x2 Vedic multiplier, instantiated four times in the top.
- The adder tree (s1 and upper-nibble sum) and the output register live in the top module.
- The 2x2 gate-level form must be preserved, not replaced by the '*' operator, so synthesis keeps the Vedic structure.

Test Plan:
- Reset: hold rst_n=1 for 2 cycles with ui_in=8'hFF -> uo_out=8'h00 throughout. Also uio_out=8'h00 and uio_oe=8'h00.
- Basic products (release reset, ena=1, apply each value and wait one rising edge):
  - ui_in={4'd3,4'd2} -> uo_out=8'd6
  - ui_in={4'd5,4'd4} -> uo_out=8'd20 (8'h14)
- Corner cases:
  - ui_in={4'd15,4'd15} -> uo_out=8'd225 (8'hE1)
  - ui_in={4'd9,4'd0} -> uo_out=8'h00
  - ui_in={4'd0,4'd9} -> uo_out=8'h00
- Enable/latency:
  - Before the next edge after an operand change, uo_out still shows the prior product.
  - With ena=0, changing ui_in to {4'd7,4'd6} -> uo_out unchanged.
  - Set ena=1 -> uo_out=8'd42 after one edge.
- Async reset mid-run: with uo_out=8'hE1, assert rst_n=1 between clock edges -> uo_out=8'h00 immediately. Release -> next edge loads the current product.
- Exhaustive sweep: all 256 ui_in values, ena=1 -> after each edge uo_out == ui_in[7:4]*ui_in[3:0].
